// File: rtl/load_store_queue_pkg.sv
// Shared payload types for the load/store queue and its memory-controller interface.
package load_store_queue_pkg;

    localparam int unsigned LSQ_XLEN  = 32;
    localparam int unsigned LSQ_ROB_W = 4;

    typedef struct packed {
        logic [LSQ_XLEN-1:0]  address;
        logic [LSQ_XLEN-1:0]  result;
        logic [LSQ_ROB_W-1:0] ROB_entry;
    } lsq_packet_t;

endpackage

// File: rtl/load_store_queue.sv
// In-order circular load/store queue between dispatch and the memory controller.
// Optional feature: define LSQ_FLUSH_EN to add a synchronous `flush` input that empties the queue.
module load_store_queue
    import load_store_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ROB_W = LSQ_ROB_W,
    parameter int unsigned XLEN  = LSQ_XLEN
) (
    input  logic                         clk,
    input  logic                         reset,
`ifdef LSQ_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic                         alloc_en,
    input  logic                         alloc_is_load,
    input  logic [ROB_W-1:0]             alloc_rob,
    input  logic                         alloc_data_ready,
    input  logic [XLEN-1:0]              alloc_data,
    input  logic [ROB_W-1:0]             alloc_data_tag,
    input  logic                         agu_valid,
    input  logic [ROB_W-1:0]             agu_rob,
    input  logic [XLEN-1:0]              agu_address,
    input  logic                         cdb_valid,
    input  logic [ROB_W-1:0]             cdb_rob,
    input  logic [XLEN-1:0]              cdb_result,
    input  logic                         rd_en,
    output lsq_packet_t                  mem_out,
    output logic                         head_load,
    output logic                         head_ready,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] is_load;
    logic [DEPTH-1:0] addr_valid;
    logic [DEPTH-1:0] data_valid;
    logic [ROB_W-1:0] rob      [DEPTH];
    logic [ROB_W-1:0] data_tag [DEPTH];
    logic [XLEN-1:0]  addr     [DEPTH];
    logic [XLEN-1:0]  data     [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic flush_i;
    logic do_alloc;
    logic do_pop;
    logic alloc_agu_hit;
    logic alloc_cdb_hit;

`ifdef LSQ_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_alloc = alloc_en && !full && !flush_i;
    assign do_pop   = rd_en && !empty && !flush_i;

    // Same-cycle forwarding into the entry being created
    assign alloc_agu_hit = agu_valid && (agu_rob == alloc_rob);
    assign alloc_cdb_hit = cdb_valid && !alloc_data_ready && (cdb_rob == alloc_data_tag);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid      <= '0;
            is_load    <= '0;
            addr_valid <= '0;
            data_valid <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                rob[i]      <= '0;
                data_tag[i] <= '0;
                addr[i]     <= '0;
                data[i]     <= '0;
            end
        end else if (flush_i) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // AGU and CDB snoop over resident entries; the tail slot is never valid here
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (agu_valid && valid[i] && !addr_valid[i] && (rob[i] == agu_rob)) begin
                    addr_valid[i] <= 1'b1;
                    addr[i]       <= agu_address;
                end
                if (cdb_valid && valid[i] && !is_load[i] && !data_valid[i] &&
                    (data_tag[i] == cdb_rob)) begin
                    data_valid[i] <= 1'b1;
                    data[i]       <= cdb_result;
                end
            end

            if (do_pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end

            if (do_alloc) begin
                valid[tail]      <= 1'b1;
                is_load[tail]    <= alloc_is_load;
                rob[tail]        <= alloc_rob;
                data_tag[tail]   <= alloc_data_tag;
                addr_valid[tail] <= alloc_agu_hit;
                addr[tail]       <= alloc_agu_hit ? agu_address : '0;
                data_valid[tail] <= alloc_is_load || alloc_data_ready || alloc_cdb_hit;
                data[tail]       <= alloc_cdb_hit ? cdb_result : alloc_data;
                tail             <= tail + PTR_W'(1);
            end

            case ({do_alloc, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry presented to the memory controller, zeroed when empty
    always_comb begin
        mem_out    = '0;
        head_load  = 1'b0;
        head_ready = 1'b0;
        if (!empty) begin
            mem_out.address   = addr[head];
            mem_out.result    = data[head];
            mem_out.ROB_entry = rob[head];
            head_load         = is_load[head];
            head_ready        = valid[head] && addr_valid[head] &&
                                (is_load[head] || data_valid[head]);
        end
    end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed self-checking bench for load_store_queue (flush case built when LSQ_FLUSH_EN is defined).
module tb_load_store_queue;
    import load_store_queue_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        alloc_en;
    logic        alloc_is_load;
    logic [3:0]  alloc_rob;
    logic        alloc_data_ready;
    logic [31:0] alloc_data;
    logic [3:0]  alloc_data_tag;
    logic        agu_valid;
    logic [3:0]  agu_rob;
    logic [31:0] agu_address;
    logic        cdb_valid;
    logic [3:0]  cdb_rob;
    logic [31:0] cdb_result;
    logic        rd_en;
    lsq_packet_t mem_out;
    logic        head_load;
    logic        head_ready;
    logic        full;
    logic        empty;
    logic [3:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    load_store_queue dut (
        .clk              (clk),
        .reset            (reset),
`ifdef LSQ_FLUSH_EN
        .flush            (flush),
`endif
        .alloc_en         (alloc_en),
        .alloc_is_load    (alloc_is_load),
        .alloc_rob        (alloc_rob),
        .alloc_data_ready (alloc_data_ready),
        .alloc_data       (alloc_data),
        .alloc_data_tag   (alloc_data_tag),
        .agu_valid        (agu_valid),
        .agu_rob          (agu_rob),
        .agu_address      (agu_address),
        .cdb_valid        (cdb_valid),
        .cdb_rob          (cdb_rob),
        .cdb_result       (cdb_result),
        .rd_en            (rd_en),
        .mem_out          (mem_out),
        .head_load        (head_load),
        .head_ready       (head_ready),
        .full             (full),
        .empty            (empty),
        .count            (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        flush            = 1'b0;
        alloc_en         = 1'b0;
        alloc_is_load    = 1'b0;
        alloc_rob        = '0;
        alloc_data_ready = 1'b0;
        alloc_data       = '0;
        alloc_data_tag   = '0;
        agu_valid        = 1'b0;
        agu_rob          = '0;
        agu_address      = '0;
        cdb_valid        = 1'b0;
        cdb_rob          = '0;
        cdb_result       = '0;
        rd_en            = 1'b0;
    endtask

    // One clock edge, then settle; inputs are returned to idle afterwards
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic alloc(input logic ld, input logic [3:0] r, input logic rdy,
                         input logic [31:0] d, input logic [3:0] tg);
        alloc_en         = 1'b1;
        alloc_is_load    = ld;
        alloc_rob        = r;
        alloc_data_ready = rdy;
        alloc_data       = d;
        alloc_data_tag   = tg;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #3;
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(head_ready), 64'd0);
        check("rst_memout", 64'(mem_out), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        // Load: alloc, then address, then pop
        alloc(1'b1, 4'd3, 1'b0, 32'h0, 4'd0);
        tick();
        check("ld_count", 64'(count), 64'd1);
        check("ld_ready_noaddr", 64'(head_ready), 64'd0);
        agu_valid = 1'b1; agu_rob = 4'd3; agu_address = 32'h40;
        tick();
        check("ld_head_load", 64'(head_load), 64'd1);
        check("ld_ready", 64'(head_ready), 64'd1);
        check("ld_addr", 64'(mem_out.address), 64'h40);
        check("ld_rob", 64'(mem_out.ROB_entry), 64'd3);
        rd_en = 1'b1;
        tick();
        check("ld_pop_empty", 64'(empty), 64'd1);
        rd_en = 1'b1;
        tick();
        check("pop_empty_ignored", 64'(count), 64'd0);

        // Store: address first, data later via CDB
        alloc(1'b0, 4'd5, 1'b0, 32'h0, 4'd2);
        tick();
        agu_valid = 1'b1; agu_rob = 4'd5; agu_address = 32'h80;
        tick();
        check("st_ready_nodata", 64'(head_ready), 64'd0);
        check("st_addr", 64'(mem_out.address), 64'h80);
        check("st_head_load", 64'(head_load), 64'd0);
        cdb_valid = 1'b1; cdb_rob = 4'd2; cdb_result = 32'hDEADBEEF;
        tick();
        check("st_ready", 64'(head_ready), 64'd1);
        check("st_data", 64'(mem_out.result), 64'hDEADBEEF);
        rd_en = 1'b1;
        tick();

        // Same-cycle alloc + AGU + CDB capture at creation
        alloc(1'b0, 4'd1, 1'b0, 32'h5555, 4'd6);
        agu_valid = 1'b1; agu_rob = 4'd1; agu_address = 32'h100;
        cdb_valid = 1'b1; cdb_rob = 4'd6; cdb_result = 32'h1234;
        tick();
        check("fwd_ready", 64'(head_ready), 64'd1);
        check("fwd_addr", 64'(mem_out.address), 64'h100);
        check("fwd_data", 64'(mem_out.result), 64'h1234);

        // Asynchronous reset mid-run, between clock edges
        #2;
        reset = 1'b0;
        #1;
        check("async_empty", 64'(empty), 64'd1);
        check("async_count", 64'(count), 64'd0);
        check("async_ready", 64'(head_ready), 64'd0);
        check("async_memout", 64'(mem_out), 64'd0);
        reset = 1'b1;
        tick();

        // Fill, overflow, alloc+pop while full
        for (int i = 0; i < 8; i++) begin
            alloc(1'b0, 4'(i), 1'b1, 32'(i * 17), 4'd0);
            tick();
        end
        check("full_flag", 64'(full), 64'd1);
        check("full_count", 64'(count), 64'd8);
        alloc(1'b0, 4'd9, 1'b1, 32'h0, 4'd0);
        tick();
        check("overflow_count", 64'(count), 64'd8);
        alloc(1'b0, 4'd10, 1'b1, 32'h0, 4'd0);
        rd_en = 1'b1;
        tick();
        check("full_pop_count", 64'(count), 64'd7);
        check("full_pop_full", 64'(full), 64'd0);
        for (int i = 1; i < 8; i++) begin
            check("drain_rob", 64'(mem_out.ROB_entry), 64'(i));
            check("drain_data", 64'(mem_out.result), 64'(i * 17));
            rd_en = 1'b1;
            tick();
        end
        check("drain_empty", 64'(empty), 64'd1);

        // Wrap: alloc/pop pairs keep program order across pointer wrap
        alloc(1'b1, 4'd0, 1'b0, 32'h0, 4'd0);
        tick();
        for (int i = 1; i < 20; i++) begin
            check("wrap_rob", 64'(mem_out.ROB_entry), 64'((i - 1) % 16));
            alloc(1'b1, 4'(i % 16), 1'b0, 32'h0, 4'd0);
            rd_en = 1'b1;
            tick();
            check("wrap_count", 64'(count), 64'd1);
        end
        check("wrap_last_rob", 64'(mem_out.ROB_entry), 64'd3);
        rd_en = 1'b1;
        tick();
        check("wrap_empty", 64'(empty), 64'd1);

`ifdef LSQ_FLUSH_EN
        for (int i = 0; i < 5; i++) begin
            alloc(1'b1, 4'(i), 1'b0, 32'h0, 4'd0);
            tick();
        end
        check("pre_flush_count", 64'(count), 64'd5);
        flush = 1'b1;
        alloc(1'b1, 4'd9, 1'b0, 32'h0, 4'd0);
        tick();
        check("flush_empty", 64'(empty), 64'd1);
        check("flush_count", 64'(count), 64'd0);
        tick();
        check("flush_alloc_dropped", 64'(count), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
